// File: rtl/stream_checker_pkg.sv
// stream_checker_pkg: shared types and helpers for the incrementing-stream checker.
//   state_t   - checker FSM states (SEARCH, LOCKED)
//   WIDTH_DEF - default data word width
//   CNT_W_DEF - default counter width
//   sat_inc   - saturating increment for counters up to MAX_CNT_W bits
package stream_checker_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned MAX_CNT_W = 32;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned         w);
        logic [MAX_CNT_W:0] lim;
        lim = ((MAX_CNT_W+1)'(1) << w) - (MAX_CNT_W+1)'(1);
        if ({1'b0, v} >= lim) begin
            return v;
        end
        return v + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst - clock and synchronous active-high reset
//   inc      - count enable
//   clr      - zero the counter next cycle (wins over inc)
//   cnt      - registered count, holds at 2^CNT_W-1
module sat_counter
    import stream_checker_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= CNT_W'(sat_inc(MAX_CNT_W'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/stream_checker.sv
// stream_checker: self-synchronising checker for an incrementing-count stream.
// Locks after SYNC_LEN consecutive in-sequence beats, then counts beats and
// mismatches; LOSS_LEN consecutive mismatches drop lock.
//   clk, rst  - clock, synchronous active-high reset
//   in_valid  - upstream beat valid
//   in_data   - upstream beat data
//   in_ready  - registered; 1 from the first cycle after reset release
//   clear     - one-cycle pulse zeroing word_cnt and err_cnt
//   locked    - high while in LOCKED
//   err_pulse - one-cycle pulse per mismatched beat while locked
//   word_cnt  - saturating count of beats accepted while locked
//   err_cnt   - saturating count of mismatched beats while locked
// Optional: define STREAM_CHECKER_DISPLAY_EN for simulation messages on
// locked mismatches and on lock gain/loss.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned SYNC_LEN = 4,
    parameter int unsigned LOSS_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RUN_W  = $clog2(SYNC_LEN + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_LEN + 1);

    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;
    logic [WIDTH-1:0]  expected;

    logic beat_c;
    logic mismatch_c;
    logic gain_c;
    logic loss_c;

    assign beat_c     = in_valid && in_ready;
    assign mismatch_c = (in_data != expected);
    // Lock gained by the in-sequence beat that brings run up to SYNC_LEN.
    assign gain_c     = beat_c && (state == SEARCH) && (run != '0) && !mismatch_c
                        && (run == RUN_W'(SYNC_LEN - 1));
    // Lock lost by the mismatch that brings miss up to LOSS_LEN.
    assign loss_c     = beat_c && (state == LOCKED) && mismatch_c
                        && (miss == MISS_W'(LOSS_LEN - 1));

    // Handshake, sync search and lock tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            state     <= SEARCH;
            run       <= '0;
            miss      <= '0;
            expected  <= '0;
        end else begin
            in_ready  <= 1'b1;
            err_pulse <= 1'b0;
            if (beat_c) begin
                case (state)
                    SEARCH: begin
                        if ((run == '0) || mismatch_c) begin
                            expected <= WIDTH'(in_data + 1'b1);
                            run      <= RUN_W'(1);
                        end else begin
                            expected <= WIDTH'(expected + 1'b1);
                            run      <= RUN_W'(run + 1'b1);
                            if (gain_c) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                miss   <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        // Lock follows the count, not the data: single errors never resync.
                        expected <= WIDTH'(expected + 1'b1);
                        if (mismatch_c) begin
                            err_pulse <= 1'b1;
                            miss      <= MISS_W'(miss + 1'b1);
                            if (loss_c) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                run    <= '0;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .inc (beat_c && (state == LOCKED)),
        .clr (clear),
        .cnt (word_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (beat_c && (state == LOCKED) && mismatch_c),
        .clr (clear),
        .cnt (err_cnt)
    );

`ifdef STREAM_CHECKER_DISPLAY_EN
    // Simulation-only trace of mismatches and lock transitions.
    always @(posedge clk) begin
        if (!rst) begin
            if (beat_c && (state == LOCKED) && mismatch_c) begin
                $display("[%0t] mismatch exp=%h got=%h", $time, expected, in_data);
            end
            if (gain_c) begin
                $display("[%0t] lock gained", $time);
            end
            if (loss_c) begin
                $display("[%0t] lock lost", $time);
            end
        end
    end
`else
    // No trace logic in the default build.
`endif

endmodule
